slave_port: RTL and testbench
=============================

SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, memory address bits received serially.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-003 SHALL have parameter SPLIT_THRESHOLD, default 4, read-wait cycles before split.
REQ-004 SHALL have ports: clk input 1 clock; rstn input 1 reset, synchronous, active-low.
REQ-005 SHALL have swdata input 1, serial address/write-data bit from bus.
REQ-006 SHALL have smode input 1, 0 read, 1 write.
REQ-007 SHALL have mvalid input 1, swdata valid; already gated by the address decoder to the selected slave.
REQ-008 SHALL have srdata output 1, serial read-data bit.
REQ-009 SHALL have svalid output 1, srdata valid.
REQ-010 SHALL have sready output 1, high only in IDLE.
REQ-011 SHALL have ssplit output 1, split request to arbiter.
REQ-012 SHALL have maddr output ADDR_WIDTH, mwdata output DATA_WIDTH, mwen output 1, mren output 1, memory request.
REQ-013 SHALL have mrdata input DATA_WIDTH and mrvalid input 1, memory read response.

Function
REQ-014 SHALL implement states IDLE, ADDR, WDATA, MWRITE, MREAD, SPLIT, RDATA, one bit-counter, one wait-counter.
REQ-015 IDLE: mvalid=1 -> addr[0]<=swdata, counter<=1, go ADDR; else stay.
REQ-016 ADDR: mvalid=1 -> addr[counter]<=swdata, counter++; mvalid=0 -> hold all (stall, no timeout).
REQ-017 ADDR, bit ADDR_WIDTH-1 accepted: latch smode, counter<=0, go WDATA if smode=1 else MREAD.
REQ-018 WDATA: mvalid=1 -> wdata[counter]<=swdata LSB first; bit DATA_WIDTH-1 accepted -> MWRITE.
REQ-019 MWRITE: mwen=1 exactly one cycle with maddr=addr, mwdata=wdata; then IDLE.
REQ-020 MREAD: mren=1 on first cycle only; wait-counter increments each cycle; mrvalid=1 -> rdata<=mrdata, go RDATA.
REQ-021 mrvalid outside MREAD/SPLIT SHALL be ignored; mrvalid on the mren cycle SHALL be accepted (zero-latency memory).
REQ-022 RDATA: svalid=1, srdata=rdata[counter], DATA_WIDTH consecutive cycles LSB first, then IDLE.
REQ-023 svalid, srdata, sready, ssplit, mwen, mren SHALL be decoded from registered state/counters only; no input-to-output combinational path.
REQ-024 maddr SHALL equal addr register at all times; mwdata SHALL equal wdata register.
REQ-025 Back-to-back transactions: IDLE lasts >=1 cycle between transactions; mvalid in MWRITE/RDATA ignored.

Reset
REQ-026 rstn=0 at clk edge -> state IDLE, counters 0, addr/wdata/rdata 0, mwen=mren=svalid=srdata=ssplit=0, sready=1 next cycle.
REQ-027 Reset mid-transaction SHALL abort with no memory write issued and no further svalid.

Configuration
REQ-028 Macro SLAVE_PORT_SPLIT_EN SHALL control split support.
REQ-029 Defined: in MREAD, wait-counter==SPLIT_THRESHOLD without mrvalid -> SPLIT; SPLIT drives ssplit=1 until mrvalid, then rdata<=mrdata, ssplit=0, go RDATA next cycle.
REQ-030 mrvalid in the same cycle wait-counter reaches SPLIT_THRESHOLD SHALL take priority (go RDATA, no split).
REQ-031 Not defined: SPLIT state unreachable, ssplit tied 0, MREAD waits indefinitely.

Verification
REQ-032 Write: 12 addr bits of 0x3A5 LSB first with smode=1, then data 0xC3 -> one-cycle mwen, maddr=0x3A5, mwdata=0xC3, return to IDLE.
REQ-033 Read, memory 1-cycle latency returning 0x5A -> mren one cycle, then svalid 8 cycles with srdata 0,1,0,1,1,0,1,0.
REQ-034 mvalid gap of 3 cycles after addr bit 5 -> address still assembled correctly, no spurious mwen.
REQ-035 With SLAVE_PORT_SPLIT_EN, mrvalid after 10 cycles -> ssplit rises after 4 wait cycles, falls on mrvalid, then 8 svalid cycles with correct data; without macro ssplit stays 0.
REQ-036 rstn=0 during WDATA bit 4 -> no mwen, sready=1 next cycle; following write of 0x001/0xFF completes normally.
REQ-037 Two back-to-back reads from 0x000 and 0xFFF -> each returns its own word, sready high between them.

Source files
------------

// File: rtl/slave_port_if.sv
// Serial bus link between a bus master/decoder and one slave port.
interface slave_port_if;
  logic swdata;
  logic smode;
  logic mvalid;
  logic srdata;
  logic svalid;
  logic sready;
  logic ssplit;

  modport master (output swdata, output smode, output mvalid,
                  input srdata, input svalid, input sready, input ssplit);
  modport slave  (input swdata, input smode, input mvalid,
                  output srdata, output svalid, output sready, output ssplit);
endinterface

// File: rtl/slave_port.sv
// Serial bus slave port: deserialises address/write data, issues memory requests, serialises read data.
// Define SLAVE_PORT_SPLIT_EN to let long memory reads raise a split request to the arbiter.
module slave_port #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SPLIT_THRESHOLD = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave_port_if.slave           bus,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [DATA_WIDTH-1:0] mwdata,
  output logic                  mwen,
  output logic                  mren,
  input  logic [DATA_WIDTH-1:0] mrdata,
  input  logic                  mrvalid
);

  localparam int unsigned MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CW   = $clog2(MAXW);
  localparam int unsigned AIW  = $clog2(ADDR_WIDTH);
  localparam int unsigned DIW  = $clog2(DATA_WIDTH);
  localparam int unsigned WW   = $clog2(SPLIT_THRESHOLD + 2);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] WDATA  = 3'd2;
  localparam logic [2:0] MWRITE = 3'd3;
  localparam logic [2:0] MREAD  = 3'd4;
  localparam logic [2:0] SPLIT  = 3'd5;
  localparam logic [2:0] RDATA  = 3'd6;

  logic [2:0]            state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [WW-1:0]         wait_q, wait_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic                  mwen_n, mren_n, svalid_n, srdata_n, sready_n, ssplit_n;

  assign maddr  = addr_q;
  assign mwdata = wdata_q;

  // Next-state and datapath decode
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    wait_n  = wait_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.mvalid) begin
          addr_n[0] = bus.swdata;
          cnt_n     = CW'(1);
          state_n   = ADDR;
        end
      end
      ADDR: begin
        if (bus.mvalid) begin
          addr_n[cnt_q[AIW-1:0]] = bus.swdata;
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_n   = '0;
            wait_n  = '0;
            state_n = bus.smode ? WDATA : MREAD;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      WDATA: begin
        if (bus.mvalid) begin
          wdata_n[cnt_q[DIW-1:0]] = bus.swdata;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_n   = '0;
            state_n = MWRITE;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      MWRITE: state_n = IDLE;
      MREAD: begin
        // Saturate so an unbounded wait cannot wrap back through the threshold
        if (wait_q != WW'(SPLIT_THRESHOLD)) wait_n = wait_q + WW'(1);
        if (mrvalid) begin
          rdata_n = mrdata;
          cnt_n   = '0;
          state_n = RDATA;
        end
`ifdef SLAVE_PORT_SPLIT_EN
        else if (wait_q == WW'(SPLIT_THRESHOLD)) begin
          state_n = SPLIT;
        end
`endif
      end
      SPLIT: begin
        if (mrvalid) begin
          rdata_n = mrdata;
          cnt_n   = '0;
          state_n = RDATA;
        end
      end
      RDATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state decodes to
  always_comb begin
    mwen_n   = (state_n == MWRITE);
    mren_n   = (state_n == MREAD) && (state_q != MREAD);
    svalid_n = (state_n == RDATA);
    srdata_n = (state_n == RDATA) ? rdata_n[cnt_n[DIW-1:0]] : 1'b0;
    sready_n = (state_n == IDLE);
`ifdef SLAVE_PORT_SPLIT_EN
    ssplit_n = (state_n == SPLIT);
`else
    ssplit_n = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mwen       <= 1'b0;
      mren       <= 1'b0;
      bus.svalid <= 1'b0;
      bus.srdata <= 1'b0;
      bus.sready <= 1'b1;
      bus.ssplit <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      wait_q     <= wait_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rdata_q    <= rdata_n;
      mwen       <= mwen_n;
      mren       <= mren_n;
      bus.svalid <= svalid_n;
      bus.srdata <= srdata_n;
      bus.sready <= sready_n;
      bus.ssplit <= ssplit_n;
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// Directed scoreboard bench for slave_port: writes, reads at several latencies, stalls, reset abort.
module tb_slave_port;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned TH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  slave_port_if bus();
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic          mwen, mren;
  logic [DW-1:0] mrdata  = '0;
  logic          mrvalid = 1'b0;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_THRESHOLD(TH)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .maddr(maddr), .mwdata(mwdata), .mwen(mwen), .mren(mren),
    .mrdata(mrdata), .mrvalid(mrvalid)
  );

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  logic [DW-1:0] rd_q [$];

  int      rd_lat = 1;
  int      pend = 0;
  logic [AW-1:0] paddr = '0;
  int      cyc = 0;
  int      mwen_cnt = 0, mren_cnt = 0;
  int      mren_cyc = 0, split_cyc = 0;
  bit      split_seen = 0;
  logic    prev_mwen = 1'b0, prev_mren = 1'b0;
  int      bitpos = 0;
  logic [DW-1:0] acc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitors, scoreboard pops and memory responder, all sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (mwen) begin
      mwen_cnt++;
      chk("mwen_single_cycle", 32'(prev_mwen), 0);
      chk("mwen_expected", 32'(wa_q.size() != 0), 1);
      if (wa_q.size() != 0) begin
        chk("maddr", 32'(maddr), 32'(wa_q.pop_front()));
        chk("mwdata", 32'(mwdata), 32'(wd_q.pop_front()));
      end
      mem[maddr] = mwdata;
    end
    prev_mwen = mwen;

    if (!rstn) begin
      bitpos = 0;
    end else if (bus.svalid) begin
      acc[bitpos] = bus.srdata;
      bitpos++;
      if (bitpos == DW) begin
        chk("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) chk("rdata", 32'(acc), 32'(rd_q.pop_front()));
        bitpos = 0;
      end
    end else if (bitpos != 0) begin
      chk("svalid_contiguous", 32'(bitpos), 0);
      bitpos = 0;
    end

    if (bus.ssplit && !split_seen) begin
      split_seen = 1;
      split_cyc  = cyc;
    end

    mrvalid = 1'b0;
    if (!rstn) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mrvalid = 1'b1;
          mrdata  = mem[paddr];
        end
      end
      if (mren) begin
        mren_cnt++;
        mren_cyc = cyc;
        chk("mren_single_cycle", 32'(prev_mren), 0);
        paddr = maddr;
        if (rd_lat == 0) begin
          mrvalid = 1'b1;
          mrdata  = mem[maddr];
        end else begin
          pend = rd_lat;
        end
      end
    end
    prev_mren = mren;
  end

  task automatic send_bits(input logic [31:0] v, input int n, input logic mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.swdata = v[i];
      bus.smode  = mode;
      bus.mvalid = 1'b1;
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.mvalid = 1'b0;
    bus.swdata = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sready && n < 100);
    chk(tag, 32'(bus.sready), 1);
  endtask

  task automatic wait_rd_done();
    int n = 0;
    while ((rd_q.size() != 0 || bitpos != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rd_done", 32'(rd_q.size()), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready("wr_ready");
    wa_q.push_back(a);
    wd_q.push_back(d);
    send_bits(32'(a), AW, 1'b1);
    send_bits(32'(d), DW, 1'b1);
    bus_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int lat, input logic [DW-1:0] d);
    int c0;
    wait_ready("rd_ready");
    mem[a]     = d;
    rd_lat     = lat;
    split_seen = 0;
    c0         = mren_cnt;
    rd_q.push_back(d);
    send_bits(32'(a), AW, 1'b0);
    bus_idle();
    wait_rd_done();
    chk("rd_mren_count", 32'(mren_cnt - c0), 1);
    wait_ready("rd_idle");
  endtask

  initial begin
    int wc;
    rstn       = 1'b0;
    bus.mvalid = 1'b0;
    bus.swdata = 1'b0;
    bus.smode  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sready", 32'(bus.sready), 1);
    chk("rst_svalid", 32'(bus.svalid), 0);
    chk("rst_srdata", 32'(bus.srdata), 0);
    chk("rst_ssplit", 32'(bus.ssplit), 0);
    chk("rst_mwen", 32'(mwen), 0);
    chk("rst_mren", 32'(mren), 0);
    chk("rst_maddr", 32'(maddr), 0);
    chk("rst_mwdata", 32'(mwdata), 0);
    rstn = 1'b1;

    // Basic write
    do_write(12'h3A5, 8'hC3);
    wait_ready("wr1_idle");
    chk("wr1_count", 32'(mwen_cnt), 1);

    // Read with one-cycle memory latency
    do_read(12'h123, 1, 8'h5A);
    chk("rd1_nosplit", 32'(split_seen), 0);

    // Address stall of three cycles after bit 5
    wait_ready("gap_ready");
    wa_q.push_back(12'h2C6);
    wd_q.push_back(8'h7E);
    send_bits(32'h2C6, 6, 1'b1);
    bus_idle();
    repeat (2) begin
      @(negedge clk);
      chk("gap_mwen", 32'(mwen), 0);
      chk("gap_sready", 32'(bus.sready), 0);
    end
    send_bits(32'h2C6 >> 6, 6, 1'b1);
    send_bits(32'h7E, DW, 1'b1);
    bus_idle();
    wait_ready("gap_idle");
    chk("gap_count", 32'(mwen_cnt), 2);

    // Zero-latency readback of the stalled write
    rd_q.push_back(8'h7E);
    wait_ready("rb_ready");
    rd_lat = 0;
    split_seen = 0;
    send_bits(32'h2C6, AW, 1'b0);
    bus_idle();
    wait_rd_done();
    wait_ready("rb_idle");
    chk("rb_nosplit", 32'(split_seen), 0);

    // Response exactly at the threshold wins over a split
    do_read(12'h0F0, TH, 8'h3C);
    chk("thresh_nosplit", 32'(split_seen), 0);

    // Long read latency
    do_read(12'h4B1, 10, 8'h96);
`ifdef SLAVE_PORT_SPLIT_EN
    chk("split_seen", 32'(split_seen), 1);
    chk("split_delay", 32'(split_cyc - mren_cyc), TH + 1);
`else
    chk("split_absent", 32'(split_seen), 0);
`endif
    chk("split_cleared", 32'(bus.ssplit), 0);

    // Reset while data bit 4 is on the bus
    wait_ready("rst_wr_ready");
    wc = mwen_cnt;
    send_bits(32'h155, AW, 1'b1);
    send_bits(32'hAA, 4, 1'b1);
    @(negedge clk);
    bus.swdata = 1'b0;
    bus.mvalid = 1'b1;
    rstn       = 1'b0;
    @(negedge clk);
    rstn       = 1'b1;
    bus.mvalid = 1'b0;
    chk("abort_sready", 32'(bus.sready), 1);
    chk("abort_mwen", 32'(mwen), 0);
    chk("abort_svalid", 32'(bus.svalid), 0);
    repeat (4) @(negedge clk);
    chk("abort_count", 32'(mwen_cnt - wc), 0);
    do_write(12'h001, 8'hFF);
    wait_ready("post_rst_idle");
    chk("post_rst_count", 32'(mwen_cnt - wc), 1);

    // Back-to-back reads at both ends of the address space
    do_read(12'h000, 1, 8'h11);
    chk("b2b_sready", 32'(bus.sready), 1);
    do_read(12'hFFF, 1, 8'hEE);

    repeat (3) @(negedge clk);
    chk("wr_queue_empty", 32'(wa_q.size()), 0);
    chk("rd_queue_empty", 32'(rd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
